// File: rtl/lsu_write_buffer_if.sv
// Request/response handshake between the MEM stage, the load/store unit and write-back.
// Master drives requests and consumes responses; slave is the load/store unit.
interface lsu_write_buffer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/lsu_write_buffer.sv
// Load/store unit with a posted-store FIFO in front of a single-port 256x8 data memory.
// Define LSU_FWD_EN for store-to-load forwarding; otherwise loads wait for an empty buffer.
module lsu_write_buffer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int HIGH_WM = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    lsu_write_buffer_if.slave    bus,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W-1:0]    mem_data,
    input  logic [DATA_W-1:0]    mem_out,
    output logic                 buf_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] HWM_CNT  = (PTR_W + 1)'(HIGH_WM);

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [DATA_W-1:0] load_data;
    logic              full, rd_acc, wr_acc, drain, load_ok;

    always_comb begin
        full      = (count_q == FULL_CNT);
        buf_empty = (count_q == '0);
        load_ok   = ~full & (~resp_valid_q | bus.resp_ready);
`ifndef LSU_FWD_EN
        load_ok   = load_ok & buf_empty;
`endif
        bus.req_ready = bus.req_write ? ~full : load_ok;
        rd_acc = bus.req_valid & ~bus.req_write & bus.req_ready;
        wr_acc = bus.req_valid & bus.req_write & bus.req_ready;
        drain  = ~rd_acc & ~buf_empty & (~bus.req_valid | (count_q >= HWM_CNT) | full);
`ifndef LSU_FWD_EN
        // A load parked on buf_empty must let the buffer drain, or it would wait forever.
        if (bus.req_valid & ~bus.req_write & ~buf_empty) drain = 1'b1;
`endif
        mem_write   = drain;
        mem_address = rd_acc ? bus.req_addr : addr_q[head_q];
        mem_data    = data_q[head_q];
    end

`ifdef LSU_FWD_EN
    logic [PTR_W-1:0] idx;

    // Later (younger) matches overwrite earlier ones while walking from head.
    always_comb begin
        idx       = head_q;
        load_data = mem_out;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count_q) && (addr_q[idx] == bus.req_addr))
                load_data = data_q[idx];
        end
    end
`else
    always_comb load_data = mem_out;
`endif

    always_comb begin
        head_d       = drain  ? head_q + 1'b1 : head_q;
        tail_d       = wr_acc ? tail_q + 1'b1 : tail_q;
        count_d      = count_q;
        case ({wr_acc, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        resp_valid_d = rd_acc ? 1'b1 : (bus.resp_ready ? 1'b0 : resp_valid_q);
        resp_data_d  = rd_acc ? load_data : resp_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            addr_q[tail_q] <= bus.req_addr;
            data_q[tail_q] <= bus.req_wdata;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
endmodule
